// File: rtl/sdram_burst_reader.sv
// sdram_burst_reader: Avalon-MM burst read DMA feeding a ready/valid stream through a credit-checked FWFT FIFO.
// Define SDRAM_RD_PERF_EN to add perf_bursts/perf_stall/perf_backpressure counters.
module sdram_burst_reader #(
    parameter int SDRAM_W    = 128,
    parameter int ADDR_W     = 32,
    parameter int BURST_W    = 11,
    parameter int MAX_BURST  = 64,
    parameter int LEN_W      = 24,
    parameter int FIFO_DEPTH = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [LEN_W-1:0]   cmd_len,
    output logic [ADDR_W-1:0]  avm_address,
    output logic [BURST_W-1:0] avm_burstcount,
    output logic               avm_read,
    input  logic               avm_waitrequest,
    input  logic [SDRAM_W-1:0] avm_readdata,
    input  logic               avm_readdatavalid,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SDRAM_W-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done
`ifdef SDRAM_RD_PERF_EN
    ,
    output logic [31:0]        perf_bursts,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_backpressure
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    pop_cnt_q, pop_cnt_d;
    logic [CW-1:0]       outstanding_q, outstanding_d;
    logic                gap_q, gap_d;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic [SDRAM_W-1:0]  mem_q [FIFO_DEPTH];

    logic [LEN_W-1:0]    burst_len;
    logic [LEN_W-1:0]    credit;
    logic                req_acc;
    logic                push;
    logic                pop;

    assign burst_len = remaining_q < LEN_W'(MAX_BURST) ? remaining_q : LEN_W'(MAX_BURST);
    // Free space counts beats already requested but not yet returned, so the slave never overruns us.
    assign credit    = LEN_W'(FIFO_DEPTH) - LEN_W'(count_q) - LEN_W'(outstanding_q);
    assign avm_read  = state_q == ISSUE && !gap_q && credit >= burst_len;
    assign avm_address    = avm_read ? cur_addr_q : '0;
    assign avm_burstcount = avm_read ? BURST_W'(burst_len) : '0;
    assign req_acc   = avm_read && !avm_waitrequest;
    assign push      = avm_readdatavalid;
    assign out_valid = count_q != '0;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q];
    assign out_last  = out_valid && pop_cnt_q == len_q - LEN_W'(1);
    assign cmd_ready = state_q == IDLE && !rst;
    assign done      = state_q == DRAIN && outstanding_q == '0 && !out_valid;
    assign busy      = state_q != IDLE && !done;
    assign count_d   = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        len_d         = len_q;
        pop_cnt_d     = pop_cnt_q + LEN_W'(pop);
        gap_d         = req_acc;
        outstanding_d = outstanding_q + (req_acc ? CW'(burst_len) : '0) - CW'(push);
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    len_d       = cmd_len;
                    pop_cnt_d   = '0;
                    state_d     = cmd_len == '0 ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (req_acc) begin
                    cur_addr_d  = cur_addr_q + ADDR_W'(burst_len);
                    remaining_d = remaining_q - burst_len;
                    state_d     = remaining_q == burst_len ? DRAIN : ISSUE;
                end
            end
            DRAIN: state_d = done ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            len_q         <= '0;
            pop_cnt_q     <= '0;
            outstanding_q <= '0;
            gap_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            len_q         <= len_d;
            pop_cnt_q     <= pop_cnt_d;
            outstanding_q <= outstanding_d;
            gap_q         <= gap_d;
            wr_ptr_q      <= wr_ptr_q + AW'(push);
            rd_ptr_q      <= rd_ptr_q + AW'(pop);
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= avm_readdata;
    end

    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push && count_q == CW'(FIFO_DEPTH) && !pop));

`ifdef SDRAM_RD_PERF_EN
    logic [31:0] perf_bursts_q, perf_stall_q, perf_bp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bursts_q <= '0;
            perf_stall_q  <= '0;
            perf_bp_q     <= '0;
        end else begin
            perf_bursts_q <= perf_bursts_q + 32'(req_acc);
            perf_stall_q  <= perf_stall_q + 32'(avm_read && avm_waitrequest);
            perf_bp_q     <= perf_bp_q + 32'(out_valid && !out_ready);
        end
    end

    assign perf_bursts       = perf_bursts_q;
    assign perf_stall        = perf_stall_q;
    assign perf_backpressure = perf_bp_q;
`endif
endmodule
